mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto one wait-stated memory port.
// Define ARB_ROUND_ROBIN_EN for alternating grants; otherwise data has fixed priority.
module mem_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              stall,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] WAIT_LAST = WAIT_STATES[3:0];
    localparam logic       GNT_IF    = 1'b0;
    localparam logic       GNT_D     = 1'b1;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              winner;
    logic              lat_we;
    logic [DATA_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              grant_d;
    logic              last_cycle;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_comb begin
        grant_d = d_req;
        if (if_req && d_req)
            grant_d = (last_grant == GNT_IF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= GNT_IF;
        else if (state == IDLE && (if_req || d_req))
            last_grant <= grant_d;
    end
`else
    assign grant_d = d_req;
`endif

    assign last_cycle = (state == BUSY) && (cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            winner    <= GNT_IF;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        winner    <= grant_d;
                        lat_addr  <= grant_d ? d_addr : if_addr;
                        lat_we    <= grant_d & d_we;
                        lat_wdata <= grant_d ? d_wdata : '0;
                        cnt       <= 4'd0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == WAIT_LAST) begin
                        if (winner == GNT_D)
                            d_rdata <= mem_rdata;
                        else
                            if_rdata <= mem_rdata;
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: strobes are decoded from state rather than registered, so an
    // asynchronous reset clears mem_we and the ready pulses without a clock edge.
    assign mem_we    = last_cycle && lat_we;
    assign if_ready  = (state == RESP) && (winner == GNT_IF);
    assign d_ready   = (state == RESP) && (winner == GNT_D);
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign stall     = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT_STATES=1, one with 0.
// Grant-order expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, d_ready, stall, mem_we;

    logic        if_req0, d_req0, d_we0;
    logic [31:0] if_addr0, d_addr0, d_wdata0;
    logic [31:0] if_rdata0, d_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
    logic        if_ready0, d_ready0, stall0, mem_we0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // memory models: fetch of 0x10 returns a fixed instruction, else a tagged address
    assign mem_rdata  = (mem_addr == 32'h10) ? 32'hE3A0_0001 : (mem_addr ^ 32'hA5A5_0000);
    assign mem_rdata0 = mem_addr0 ^ 32'hA5A5_0000;

    mem_arbiter #(.WAIT_STATES(1), .DATA_W(32)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .stall(stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.WAIT_STATES(0), .DATA_W(32)) u_dut0 (
        .clk(clk), .reset(reset),
        .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0), .if_ready(if_ready0),
        .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
        .d_rdata(d_rdata0), .d_ready(d_ready0), .stall(stall0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0), .mem_rdata(mem_rdata0)
    );

    task automatic test_reset();
        reset = 1'b1;
        if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
        if_req0 = 0; d_req0 = 0; d_we0 = 0; if_addr0 = 0; d_addr0 = 0; d_wdata0 = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({if_ready, d_ready, mem_we, stall} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes got %b exp 0000", {if_ready, d_ready, mem_we, stall});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'd0) begin
            errors++; $display("FAIL reset_regs got %h %h %h %h exp zeros", mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        checks++;
        if ({if_ready0, d_ready0, mem_we0, mem_addr0} !== 35'd0) begin
            errors++; $display("FAIL reset_dut0 got %b %b %b %h exp zeros", if_ready0, d_ready0, mem_we0, mem_addr0);
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0 got %b exp 1", stall); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (if_ready !== (k == 3) || stall !== (k != 3)) begin
                errors++; $display("FAIL fetch_timing cycle N+%0d got ready %b stall %b exp ready %b stall %b",
                                   k, if_ready, stall, (k == 3), (k != 3));
            end
        end
        checks++;
        if (if_rdata !== 32'hE3A0_0001 || d_ready !== 1'b0) begin
            errors++; $display("FAIL fetch_rdata got %h d_ready %b exp e3a00001 0", if_rdata, d_ready);
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b0 || stall !== 1'b0 || if_rdata !== 32'hE3A0_0001) begin
            errors++; $display("FAIL fetch_hold got ready %b stall %b rdata %h exp 0 0 e3a00001", if_ready, stall, if_rdata);
        end
    endtask

    task automatic test_store();
        int we_cnt, rdy_cnt, we_k, rdy_k;
        logic [31:0] wa, wd;
        we_cnt = 0; rdy_cnt = 0; we_k = -1; rdy_k = -1; wa = 0; wd = 0;
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h64; d_wdata = 32'd7;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_we) begin we_cnt++; we_k = k; wa = mem_addr; wd = mem_wdata; end
            if (d_ready) begin rdy_cnt++; rdy_k = k; d_req = 0; d_we = 0; end
        end
        checks++;
        if (we_cnt !== 1 || wa !== 32'h64 || wd !== 32'd7) begin
            errors++; $display("FAIL store_write got count %0d addr %h data %h exp 1 64 7", we_cnt, wa, wd);
        end
        checks++;
        if (rdy_cnt !== 1 || we_k !== 1 || rdy_k !== 2) begin
            errors++; $display("FAIL store_ready got count %0d we_at %0d rdy_at %0d exp 1 1 2", rdy_cnt, we_k, rdy_k);
        end
    endtask

    task automatic test_priority();
        int n;
        logic [3:0] seq, exp_seq;
        n = 0; seq = 4'b0000;
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = 4'b0101;
`else
        exp_seq = 4'b1111;
`endif
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if_ready && d_ready) begin
                checks++; errors++; $display("FAIL prio_dual_ready got both ready exp one");
            end
            if (d_ready || if_ready) begin
                seq[n] = d_ready;
                n++;
            end
            if (n == 4) begin if_req = 0; d_req = 0; break; end
        end
        checks++;
        if (n !== 4 || seq !== exp_seq) begin
            errors++; $display("FAIL prio_order got %0d grants seq %b exp 4 %b (bit0 first, 1=D)", n, seq, exp_seq);
        end
        checks++;
        if (d_rdata !== 32'hA5A5_0080) begin
            errors++; $display("FAIL prio_d_rdata got %h exp a5a50080", d_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int r [2];
        logic [31:0] a [2];
        logic [31:0] dat [2];
        n = 0; r = '{-1, -1}; a = '{0, 0}; dat = '{0, 0};
        @(negedge clk);
        if_req0 = 1; if_addr0 = 32'h0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (if_ready0 && n < 2) begin
                r[n] = k; a[n] = mem_addr0; dat[n] = if_rdata0;
                n++;
                if (n == 1) if_addr0 = 32'h4;
                else if_req0 = 0;
            end
        end
        checks++;
        if (n !== 2 || r[0] !== 2 || r[1] !== 5) begin
            errors++; $display("FAIL b2b_timing got %0d pulses at %0d %0d exp 2 at 2 5", n, r[0], r[1]);
        end
        checks++;
        if (a[0] !== 32'h0 || a[1] !== 32'h4) begin
            errors++; $display("FAIL b2b_addr got %h %h exp 0 4", a[0], a[1]);
        end
        checks++;
        if (dat[0] !== 32'hA5A5_0000 || dat[1] !== 32'hA5A5_0004) begin
            errors++; $display("FAIL b2b_rdata got %h %h exp a5a50000 a5a50004", dat[0], dat[1]);
        end
    endtask

    task automatic test_drop();
        int rdy_cnt, we_cnt;
        rdy_cnt = 0; we_cnt = 0;
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h20;
        @(negedge clk);
        d_req = 0; d_addr = 32'h99;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (d_ready) rdy_cnt++;
            if (mem_we) we_cnt++;
        end
        checks++;
        if (rdy_cnt !== 1 || we_cnt !== 0) begin
            errors++; $display("FAIL drop_count got ready %0d writes %0d exp 1 0", rdy_cnt, we_cnt);
        end
        checks++;
        if (d_rdata !== 32'hA5A5_0020 || stall !== 1'b0) begin
            errors++; $display("FAIL drop_rdata got %h stall %b exp a5a50020 0", d_rdata, stall);
        end
    endtask

    task automatic test_reset_abort();
        logic found;
        int rdy_cnt, we_cnt, bad_we;
        found = 0; rdy_cnt = 0; we_cnt = 0; bad_we = 0;
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'h55;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_we) begin found = 1; break; end
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL abort_we_seen got %b exp 1", found); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || d_ready !== 1'b0) begin
            errors++; $display("FAIL abort_async got mem_we %b d_ready %b exp 0 0", mem_we, d_ready);
        end
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL abort_held got d_ready %b mem_addr %h exp 0 0", d_ready, mem_addr);
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                if (mem_addr !== 32'h30 || mem_wdata !== 32'h55) bad_we++;
            end
            if (d_ready) begin rdy_cnt++; d_req = 0; d_we = 0; end
        end
        checks++;
        if (we_cnt !== 1 || bad_we !== 0 || rdy_cnt !== 1) begin
            errors++; $display("FAIL abort_regrant got writes %0d bad %0d ready %0d exp 1 0 1", we_cnt, bad_we, rdy_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_priority();
        test_back_to_back();
        test_drop();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
